vga_vblank_arbiter: RTL and testbench

//  Shares one write port into the display config register file (object position, colour, etc.)

---
 rtl/vga_vblank_arbiter.sv | 145 ++++++++++++++
 tb/tb_vga_vblank_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_vblank_arbiter.sv
// Round-robin arbiter granting config register writes only inside vertical blanking.
// Optional stall statistics are enabled by defining VBLANK_ARB_STATS_EN.
module vga_vblank_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 4,
  parameter int DW     = 12,
  parameter int MAX_WR = 8
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vblnk,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] wr_addr_in,
  input  logic [NREQ*DW-1:0] wr_data_in,
  output logic [NREQ-1:0]    ack,
  output logic               cfg_we,
  output logic [AW-1:0]      cfg_addr,
  output logic [DW-1:0]      cfg_data,
  output logic               busy,
  output logic [15:0]        stall_cnt,
  output logic [1:0]         dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Handshake: req[i] is a level held with its address/data slice stable until ack[i];
  // ack[i] is a single-cycle pulse coincident with cfg_we, and the requester drops req or
  // presents its next item on the following cycle. WRITE always returns to SCAN, so a stale
  // req in the cycle after ack is never re-granted.

  state_t          state, state_nx;
  logic            vblnk_d;
  logic            rise;
  logic [PW-1:0]   rr_ptr, rr_ptr_nx;
  logic [7:0]      wr_cnt, wr_cnt_nx;
  logic [NREQ-1:0] ack_nx;
  logic            we_nx;
  logic            busy_nx;
  logic [AW-1:0]   addr_nx;
  logic [DW-1:0]   data_nx;
  logic            found;
  int              win_i;
  int              idx;

  assign rise      = vblnk & ~vblnk_d;
  assign dbg_state = state;

  // First set request at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win_i = 0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win_i = idx;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    wr_cnt_nx = wr_cnt;
    ack_nx    = '0;
    we_nx     = 1'b0;
    addr_nx   = cfg_addr;
    data_nx   = cfg_data;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx  = SCAN;
          wr_cnt_nx = '0;
        end
      end
      SCAN: begin
        if (!vblnk) begin
          state_nx = IDLE;
        end else if (wr_cnt == 8'(MAX_WR)) begin
          state_nx = DONE;
        end else if (found) begin
          state_nx      = WRITE;
          ack_nx[win_i] = 1'b1;
          we_nx         = 1'b1;
          addr_nx       = wr_addr_in[win_i*AW +: AW];
          data_nx       = wr_data_in[win_i*DW +: DW];
          rr_ptr_nx     = PW'((win_i + 1) % NREQ);
          wr_cnt_nx     = 8'(wr_cnt + 8'd1);
        end
      end
      WRITE: state_nx = SCAN;
      DONE: begin
        if (!vblnk) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == SCAN) || (state_nx == WRITE);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= IDLE;
      vblnk_d  <= 1'b1;
      rr_ptr   <= '0;
      wr_cnt   <= '0;
      ack      <= '0;
      cfg_we   <= 1'b0;
      cfg_addr <= '0;
      cfg_data <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      vblnk_d  <= vblnk;
      rr_ptr   <= rr_ptr_nx;
      wr_cnt   <= wr_cnt_nx;
      ack      <= ack_nx;
      cfg_we   <= we_nx;
      cfg_addr <= addr_nx;
      cfg_data <= data_nx;
      busy     <= busy_nx;
    end
  end

`ifdef VBLANK_ARB_STATS_EN
  // A frame "stalls" when blanking ends with any request still waiting.
  always_ff @(posedge pclk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (vblnk_d && !vblnk && (|req) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_vblank_arbiter.sv
// Directed bench for vga_vblank_arbiter: per-cycle vector table plus hand-written frame sequences.
module tb_vga_vblank_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 12;
`ifdef VBLANK_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               pclk;
  logic               rst;
  logic               vblnk;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] wr_addr_in;
  logic [NREQ*DW-1:0] wr_data_in;
  logic [NREQ-1:0]    ack;
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [DW-1:0]      cfg_data;
  logic               busy;
  logic [15:0]        stall_cnt;
  logic [1:0]         dbg_state;

  vga_vblank_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_WR(8)) dut (
    .pclk(pclk), .rst(rst), .vblnk(vblnk), .req(req),
    .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .ack(ack), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] pending;
  logic       prev_we;
  int         ack_seen;

  typedef struct {
    logic       rst;
    logic       vblnk;
    logic [3:0] req;
    logic [3:0] ack;
    logic       we;
    logic       busy;
    logic [1:0] st;
    logic [15:0] stall;
  } vec_t;

  vec_t vecs[22];

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(i * 3 + 1);
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return DW'(256 * (i + 1) + i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // driver: runs n cycles, requesters present 'pending'; scoreboard checks every ack
  task automatic run(input int n, input bit drop);
    for (int c = 0; c < n; c++) begin
      req = pending;
      step();
      check("ack_vs_we", 32'(|ack), 32'(cfg_we));
      if (cfg_we) check("we_gap", 32'(prev_we), 32'd0);
      prev_we = cfg_we;
      if (ack != 4'd0) begin
        int w;
        w = 0;
        ack_seen++;
        check("ack_onehot", 32'($countones(ack)), 32'd1);
        for (int k = 0; k < NREQ; k++) if (ack[k]) w = k;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack=%b expected none", ack);
        end else begin
          check("grant_idx", 32'(w), 32'(exp_q.pop_front()));
        end
        check("grant_addr", 32'(cfg_addr), 32'(addr_of(w)));
        check("grant_data", 32'(cfg_data), 32'(data_of(w)));
        if (drop) pending &= ~ack;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vblnk = 1'b1;
    pending = '0;
    req = '0;
    step();
    step();
    rst = 1'b0;
    prev_we = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    vblnk = 1'b1;
    req = '0;
    pending = '0;
    prev_we = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < NREQ; i++) begin
      wr_addr_in[i*AW +: AW] = addr_of(i);
      wr_data_in[i*DW +: DW] = data_of(i);
    end

    // rst vblnk req   | ack  we busy state stall(with stats)
    vecs[0]  = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 16'd0};
    vecs[4]  = '{1'b0, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 16'd1};
    vecs[5]  = '{1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 1'b1, 2'd1, 16'd1};
    vecs[6]  = '{1'b0, 1'b1, 4'h1, 4'h1, 1'b1, 1'b1, 2'd2, 16'd1};
    vecs[7]  = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 16'd1};
    vecs[8]  = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 16'd1};
    vecs[9]  = '{1'b0, 1'b0, 4'h4, 4'h0, 1'b0, 1'b0, 2'd0, 16'd2};
    vecs[10] = '{1'b0, 1'b0, 4'h4, 4'h0, 1'b0, 1'b0, 2'd0, 16'd2};
    vecs[11] = '{1'b0, 1'b0, 4'h4, 4'h0, 1'b0, 1'b0, 2'd0, 16'd2};
    vecs[12] = '{1'b0, 1'b1, 4'h4, 4'h0, 1'b0, 1'b1, 2'd1, 16'd2};
    vecs[13] = '{1'b0, 1'b1, 4'h4, 4'h4, 1'b1, 1'b1, 2'd2, 16'd2};
    vecs[14] = '{1'b0, 1'b0, 4'h2, 4'h0, 1'b0, 1'b1, 2'd1, 16'd3};
    vecs[15] = '{1'b0, 1'b0, 4'h2, 4'h0, 1'b0, 1'b0, 2'd0, 16'd3};
    vecs[16] = '{1'b0, 1'b0, 4'h2, 4'h0, 1'b0, 1'b0, 2'd0, 16'd3};
    vecs[17] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 16'd3};
    vecs[18] = '{1'b0, 1'b1, 4'h2, 4'h0, 1'b0, 1'b1, 2'd1, 16'd3};
    vecs[19] = '{1'b0, 1'b1, 4'h2, 4'h2, 1'b1, 1'b1, 2'd2, 16'd3};
    vecs[20] = '{1'b1, 1'b1, 4'h2, 4'h0, 1'b0, 1'b0, 2'd0, 16'd0};
    vecs[21] = '{1'b0, 1'b1, 4'h2, 4'h0, 1'b0, 1'b0, 2'd0, 16'd0};

    for (int v = 0; v < 22; v++) begin
      rst = vecs[v].rst;
      vblnk = vecs[v].vblnk;
      req = vecs[v].req;
      step();
      check($sformatf("v%0d_ack", v), 32'(ack), 32'(vecs[v].ack));
      check($sformatf("v%0d_we", v), 32'(cfg_we), 32'(vecs[v].we));
      check($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
      check($sformatf("v%0d_state", v), 32'(dbg_state), 32'(vecs[v].st));
      check($sformatf("v%0d_stall", v), 32'(stall_cnt), STATS ? 32'(vecs[v].stall) : 32'd0);
      if (vecs[v].rst) begin
        check($sformatf("v%0d_addr_rst", v), 32'(cfg_addr), 32'd0);
        check($sformatf("v%0d_data_rst", v), 32'(cfg_data), 32'd0);
      end
      if (vecs[v].we) begin
        int w;
        w = 0;
        for (int k = 0; k < NREQ; k++) if (vecs[v].ack[k]) w = k;
        check($sformatf("v%0d_addr", v), 32'(cfg_addr), 32'(addr_of(w)));
        check($sformatf("v%0d_data", v), 32'(cfg_data), 32'(data_of(w)));
      end
    end

    // all four request, each drops after its grant: order 0,1,2,3
    do_reset();
    vblnk = 1'b0;
    run(1, 1'b1);
    pending = 4'hF;
    vblnk = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(4'(i));
    run(12, 1'b1);
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    check("t2_pending", 32'(pending), 32'd0);

    // all four held: MAX_WR grants, then DONE until next frame
    do_reset();
    vblnk = 1'b0;
    run(1, 1'b0);
    pending = 4'hF;
    vblnk = 1'b1;
    ack_seen = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(4'(i % 4));
    run(24, 1'b0);
    check("t3_acks", 32'(ack_seen), 32'd8);
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    check("t3_done", 32'(dbg_state), 32'd3);
    vblnk = 1'b0;
    run(3, 1'b0);
    check("t3_idle", 32'(dbg_state), 32'd0);
    exp_q.push_back(4'd0);
    vblnk = 1'b1;
    run(2, 1'b0);
    check("t3_next_frame_first", 32'(exp_q.size()), 32'd0);
    vblnk = 1'b0;
    run(3, 1'b0);

    // stall statistics over three frames
    do_reset();
    vblnk = 1'b0;
    run(1, 1'b1);
    pending = 4'h8;
    exp_q.push_back(4'd3);
    vblnk = 1'b1;
    run(6, 1'b1);
    vblnk = 1'b0;
    run(2, 1'b1);
    check("t6_stall_f1", 32'(stall_cnt), 32'd0);
    pending = 4'h9;
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd0);
    vblnk = 1'b1;
    run(6, 1'b0);
    vblnk = 1'b0;
    run(2, 1'b0);
    check("t6_stall_f2", 32'(stall_cnt), STATS ? 32'd1 : 32'd0);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd3);
    vblnk = 1'b1;
    run(6, 1'b0);
    vblnk = 1'b0;
    run(2, 1'b0);
    check("t6_stall_f3", 32'(stall_cnt), STATS ? 32'd2 : 32'd0);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
